// File: rtl/fir_feeder_pkg.sv
// Shared types for the fir_filter feeder: FSM states, FIFO entry layout, data width.
package fir_feeder_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LC_PULSE,
      ST_LC_WAIT_BUSY,
      ST_LC_WAIT_DONE,
      ST_DR_ASSERT,
      ST_DR_WAIT_DONE
   } feeder_state_t;

   typedef struct packed {
      logic              is_coeff;
      logic [DATA_W-1:0] data;
   } feeder_entry_t;

   localparam int ENTRY_W = $bits(feeder_entry_t);

   // States in which the filter is being waited on and the timeout may fire.
   function automatic logic is_timed_state(input feeder_state_t s);
      return (s == ST_LC_WAIT_BUSY) || (s == ST_LC_WAIT_DONE) ||
             (s == ST_DR_ASSERT)    || (s == ST_DR_WAIT_DONE);
   endfunction

endpackage

// File: rtl/fir_feeder_if.sv
// Host write port plus fir_filter handshake, bundled; master is the feeder side.
interface fir_feeder_if;
   import fir_feeder_pkg::*;

   logic              wr_en;
   logic              wr_is_coeff;
   logic [DATA_W-1:0] wr_data;
   logic              clr_err;
   logic              modwait;
   logic              wr_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] sample_data;
   logic [DATA_W-1:0] fir_coefficient;
   logic              data_ready;
   logic              load_coeff;
   logic              busy;
   logic              overflow_err;
   logic              timeout_err;

   modport master (
      input  wr_en, wr_is_coeff, wr_data, clr_err, modwait,
      output wr_full, fifo_empty, sample_data, fir_coefficient,
             data_ready, load_coeff, busy, overflow_err, timeout_err
   );

   modport slave (
      output wr_en, wr_is_coeff, wr_data, clr_err, modwait,
      input  wr_full, fifo_empty, sample_data, fir_coefficient,
             data_ready, load_coeff, busy, overflow_err, timeout_err
   );

endinterface

// File: rtl/fir_feeder_sync_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on o_dout while not empty.
module sync_fifo #(
   parameter int DATA_W = 17,
   parameter int DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_push,
   input  logic [DATA_W-1:0]         i_din,
   input  logic                      i_pop,
   output logic [DATA_W-1:0]         o_dout,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [$clog2(DEPTH):0]    o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/fir_feeder.sv
// Buffers tagged coefficient/sample words and replays them to fir_filter over
// the load_coeff / data_ready / modwait handshake with timeout and sticky errors.
module fir_feeder
   import fir_feeder_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int LC_PULSE = 2,
   parameter int TIMEOUT  = 25
) (
   input  logic         clk,
   input  logic         reset,
   fir_feeder_if.master bus
);

   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int TMAX = (TIMEOUT > LC_PULSE) ? TIMEOUT : LC_PULSE;
   localparam int TW   = $clog2(TMAX + 1);

   feeder_state_t     r_state;
   feeder_state_t     w_next;
   logic [TW-1:0]     r_cnt;
   logic              r_mw_seen;
   logic              w_tmo;
   logic              w_tmo_hit;

   feeder_entry_t     w_din;
   feeder_entry_t     w_head;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;

   logic              w_dr_nxt;
   logic              w_lc_nxt;
   logic              w_busy_nxt;
   logic              r_dr;
   logic              r_lc;
   logic              r_busy;
   logic [DATA_W-1:0] r_sample;
   logic [DATA_W-1:0] r_coef;
   logic              r_ovf;
   logic              r_tmo;

   assign w_din  = {bus.wr_is_coeff, bus.wr_data};
   // Full is judged on the pre-pop count, so a write while full is always dropped.
   assign w_push = bus.wr_en && !w_full;
   assign w_pop  = (r_state == ST_IDLE) && !w_empty;

   sync_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   a_count_bound: assert property (@(posedge clk) disable iff (reset)
      (w_count <= CW'(DEPTH)));

   assign w_tmo = is_timed_state(r_state) && (r_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_tmo_hit = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) w_next = w_head.is_coeff ? ST_LC_PULSE : ST_DR_ASSERT;
         end
         ST_LC_PULSE: begin
            // The filter may already answer during the pulse; skip the busy wait then.
            if (r_cnt == TW'(LC_PULSE - 1))
               w_next = (r_mw_seen || bus.modwait) ? ST_LC_WAIT_DONE : ST_LC_WAIT_BUSY;
         end
         ST_LC_WAIT_BUSY: begin
            if (bus.modwait)  w_next = ST_LC_WAIT_DONE;
            else if (w_tmo) begin w_next = ST_IDLE; w_tmo_hit = 1'b1; end
         end
         ST_LC_WAIT_DONE: begin
            if (!bus.modwait) w_next = ST_IDLE;
            else if (w_tmo) begin w_next = ST_IDLE; w_tmo_hit = 1'b1; end
         end
         ST_DR_ASSERT: begin
            if (bus.modwait)  w_next = ST_DR_WAIT_DONE;
            else if (w_tmo) begin w_next = ST_IDLE; w_tmo_hit = 1'b1; end
         end
         ST_DR_WAIT_DONE: begin
            if (!bus.modwait) w_next = ST_IDLE;
            else if (w_tmo) begin w_next = ST_IDLE; w_tmo_hit = 1'b1; end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_lc_nxt   = (w_next == ST_LC_PULSE);
      w_dr_nxt   = (w_next == ST_DR_ASSERT);
      w_busy_nxt = (w_next != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_mw_seen <= 1'b0;
      end else begin
         if (w_next != r_state)       r_cnt <= '0;
         else if (r_state != ST_IDLE) r_cnt <= r_cnt + TW'(1);
         if (r_state != ST_LC_PULSE)  r_mw_seen <= 1'b0;
         else if (bus.modwait)        r_mw_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dr     <= 1'b0;
         r_lc     <= 1'b0;
         r_busy   <= 1'b0;
         r_sample <= '0;
         r_coef   <= '0;
      end else begin
         r_dr   <= w_dr_nxt;
         r_lc   <= w_lc_nxt;
         r_busy <= w_busy_nxt;
         if (w_pop &&  w_head.is_coeff) r_coef   <= w_head.data;
         if (w_pop && !w_head.is_coeff) r_sample <= w_head.data;
      end
   end

   // Sticky flags: a set event in the same cycle as clr_err takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
         r_tmo <= 1'b0;
      end else begin
         if (bus.wr_en && w_full) r_ovf <= 1'b1;
         else if (bus.clr_err)    r_ovf <= 1'b0;
         if (w_tmo_hit)           r_tmo <= 1'b1;
         else if (bus.clr_err)    r_tmo <= 1'b0;
      end
   end

   assign bus.wr_full         = w_full;
   assign bus.fifo_empty      = w_empty;
   assign bus.sample_data     = r_sample;
   assign bus.fir_coefficient = r_coef;
   assign bus.data_ready      = r_dr;
   assign bus.load_coeff      = r_lc;
   assign bus.busy            = r_busy;
   assign bus.overflow_err    = r_ovf;
   assign bus.timeout_err     = r_tmo;

endmodule

// File: tb/tb_fir_feeder.sv
// Directed bench for fir_feeder: scripted filter responder, scoreboard monitor on handshake words.
module tb_fir_feeder;
   import fir_feeder_pkg::*;

   localparam int DEPTH    = 8;
   localparam int LC_PULSE = 2;
   localparam int TIMEOUT  = 25;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   mode       = 0;   // 0: respond to handshakes, 1: modwait held high, 2: modwait held low
   int   resp_delay = 0;
   feeder_entry_t exp_q[$];

   fir_feeder_if bus_if ();

   fir_feeder #(.DEPTH(DEPTH), .LC_PULSE(LC_PULSE), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic wr(input logic c, input logic [15:0] d, input bit acc);
      feeder_entry_t e;
      @(negedge clk);
      bus_if.wr_en = 1'b1;
      bus_if.wr_is_coeff = c;
      bus_if.wr_data = d;
      if (acc) begin
         e.is_coeff = c;
         e.data = d;
         exp_q.push_back(e);
      end
   endtask

   task automatic wr_end();
      @(negedge clk);
      bus_if.wr_en = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      bus_if.clr_err = 1'b1;
      @(negedge clk);
      bus_if.clr_err = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || bus_if.busy || !bus_if.fifo_empty) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(name, (n < 3000), 1);
   endtask

   // Filter stand-in: drives modwait according to the selected mode.
   initial begin
      bus_if.modwait = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (mode == 1) bus_if.modwait = 1'b1;
         else if (mode == 2) bus_if.modwait = 1'b0;
         else if (bus_if.data_ready || bus_if.load_coeff) begin
            repeat (resp_delay) @(posedge clk);
            #1 bus_if.modwait = 1'b1;
            repeat (3) @(posedge clk);
            #1 bus_if.modwait = 1'b0;
         end else bus_if.modwait = 1'b0;
      end
   end

   // Scoreboard monitor: each rising handshake must present the next queued word.
   initial begin
      logic prev_dr = 1'b0;
      logic prev_lc = 1'b0;
      int   lc_w = 0;
      feeder_entry_t e;
      logic got_c;
      logic [15:0] got_d;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_dr = 1'b0;
            prev_lc = 1'b0;
            lc_w = 0;
         end else begin
            if (bus_if.load_coeff) lc_w++;
            else if (prev_lc) begin
               chk("lc_pulse_width", lc_w, LC_PULSE);
               lc_w = 0;
            end
            if ((bus_if.data_ready && !prev_dr) || (bus_if.load_coeff && !prev_lc)) begin
               got_c = bus_if.load_coeff;
               got_d = got_c ? bus_if.fir_coefficient : bus_if.sample_data;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_word got kind=%0d data=%0h expected none", got_c, got_d);
               end else begin
                  e = exp_q.pop_front();
                  chk("word_kind", got_c, e.is_coeff);
                  chk("word_data", got_d, e.data);
               end
            end
            prev_dr = bus_if.data_ready;
            prev_lc = bus_if.load_coeff;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int cnt;
      reset = 1'b1;
      bus_if.wr_en = 1'b0;
      bus_if.wr_is_coeff = 1'b0;
      bus_if.wr_data = '0;
      bus_if.clr_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data_ready", bus_if.data_ready, 0);
      chk("rst_load_coeff", bus_if.load_coeff, 0);
      chk("rst_busy", bus_if.busy, 0);
      chk("rst_wr_full", bus_if.wr_full, 0);
      chk("rst_overflow", bus_if.overflow_err, 0);
      chk("rst_timeout", bus_if.timeout_err, 0);
      chk("rst_fifo_empty", bus_if.fifo_empty, 1);
      chk("rst_sample", bus_if.sample_data, 0);
      chk("rst_coef", bus_if.fir_coefficient, 0);
      reset = 1'b0;

      // Latency: write at n, head at n+1, data_ready at n+2.
      wr(1'b0, 16'h0055, 1'b1);
      wr_end();
      chk("lat_n1_not_empty", bus_if.fifo_empty, 0);
      chk("lat_n1_dr_low", bus_if.data_ready, 0);
      @(negedge clk);
      chk("lat_n2_dr_high", bus_if.data_ready, 1);
      chk("lat_n2_busy", bus_if.busy, 1);
      wait_drain("lat_drain");

      // Coefficients 0.5, 1.0, 1.0, 0.5 then four samples of 100.
      wr(1'b1, 16'h4000, 1'b1);
      wr(1'b1, 16'h8000, 1'b1);
      wr(1'b1, 16'h8000, 1'b1);
      wr(1'b1, 16'h4000, 1'b1);
      for (int i = 0; i < 4; i++) wr(1'b0, 16'd100, 1'b1);
      wr_end();
      wait_drain("coef_drain");
      chk("coef_no_timeout", bus_if.timeout_err, 0);

      // Slow filter: modwait rises only after the load_coeff pulse has ended.
      resp_delay = 4;
      wr(1'b1, 16'h1357, 1'b1);
      wr(1'b0, 16'h2468, 1'b1);
      wr_end();
      wait_drain("slow_drain");
      chk("slow_no_timeout", bus_if.timeout_err, 0);
      resp_delay = 0;

      // Back-pressure: a primer word parks the FSM in DR_WAIT_DONE, then 9 writes.
      mode = 1;
      wr(1'b0, 16'h0001, 1'b1);
      wr_end();
      repeat (3) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) wr(1'b0, 16'h0010 + 16'(i), 1'b1);
      @(negedge clk);
      chk("bp_full_after_8", bus_if.wr_full, 1);
      chk("bp_ovf_before_9", bus_if.overflow_err, 0);
      bus_if.wr_data = 16'h0BAD;
      bus_if.clr_err = 1'b1;
      @(negedge clk);
      bus_if.wr_en = 1'b0;
      bus_if.clr_err = 1'b0;
      chk("bp_ovf_set_wins", bus_if.overflow_err, 1);
      chk("bp_still_full", bus_if.wr_full, 1);
      pulse_clr();
      chk("bp_ovf_cleared", bus_if.overflow_err, 0);
      mode = 0;
      wait_drain("bp_drain");
      chk("bp_no_timeout", bus_if.timeout_err, 0);

      // Timeout: modwait never responds to a sample.
      mode = 2;
      wr(1'b0, 16'h1234, 1'b1);
      wr_end();
      n = 0;
      while (!bus_if.data_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_dr_rose", bus_if.data_ready, 1);
      cnt = 0;
      while (bus_if.data_ready && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("tmo_dr_cycles", cnt, TIMEOUT);
      chk("tmo_err_set", bus_if.timeout_err, 1);
      chk("tmo_idle", bus_if.busy, 0);

      // Error clear, then a normal transfer.
      pulse_clr();
      chk("clr_tmo_err", bus_if.timeout_err, 0);
      mode = 0;
      wr(1'b0, 16'h0042, 1'b1);
      wr_end();
      wait_drain("clr_drain");
      chk("clr_tmo_stays", bus_if.timeout_err, 0);

      // Reset mid-transfer, with one word still queued.
      mode = 1;
      wr(1'b0, 16'h0777, 1'b1);
      wr_end();
      repeat (2) @(negedge clk);
      chk("mid_busy", bus_if.busy, 1);
      chk("mid_dr_dropped", bus_if.data_ready, 0);
      wr(1'b0, 16'h0888, 1'b0);
      @(negedge clk);
      bus_if.wr_en = 1'b0;
      reset = 1'b1;
      chk("mid_fifo_loaded", bus_if.fifo_empty, 0);
      @(negedge clk);
      chk("mrst_data_ready", bus_if.data_ready, 0);
      chk("mrst_load_coeff", bus_if.load_coeff, 0);
      chk("mrst_busy", bus_if.busy, 0);
      chk("mrst_fifo_empty", bus_if.fifo_empty, 1);
      chk("mrst_sample", bus_if.sample_data, 0);
      chk("mrst_wr_full", bus_if.wr_full, 0);
      reset = 1'b0;
      mode = 0;
      repeat (4) @(negedge clk);
      chk("post_rst_idle", bus_if.busy, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_feeder.md
# fir_feeder

- Upstream stage of `fir_filter`.
- Accepts a host-side stream of tagged 16-bit words: coefficients or samples.
- Buffers them in order in a small synchronous FIFO.
- Replays each word to the filter over the filter's `load_coeff` / `data_ready` / `modwait` handshake, with per-transfer timeout and sticky error reporting.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `LC_PULSE`, 2: cycles `load_coeff` is held; covers the filter's input synchronizer.
- `TIMEOUT`, 25: max cycles spent waiting on a `modwait` edge.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `wr_en`  in  1  host write strobe
- `wr_is_coeff`  in  1  1 = coefficient, 0 = sample
- `wr_data`  in  16  coefficient (Q1.15 unsigned, 0x8000 = 1.0) or sample
- `clr_err`  in  1  clears `overflow_err` and `timeout_err`
- `modwait`  in  1  filter busy, from `fir_filter`
- `wr_full`  out  1  FIFO full; combinational from count
- `fifo_empty`  out  1  FIFO empty
- `sample_data`  out  16  to `fir_filter.sample_data`
- `fir_coefficient`  out  16  to `fir_filter.fir_coefficient`
- `data_ready`  out  1  sample handshake
- `load_coeff`  out  1  coefficient handshake
- `busy`  out  1  FSM not in IDLE
- `overflow_err`  out  1  sticky: write attempted while full
- `timeout_err`  out  1  sticky: `modwait` failed to respond

## Operation
- **FIFO entry format:** `{is_coeff, data[15:0]}`, 17 bits. Entries are strictly in order; coefficients and samples share the queue.
- **Write side:**
  - Write accepted when `wr_en && !wr_full`.
  - `wr_full` is judged before any same-cycle pop, so a write while full is dropped and sets `overflow_err`.
- **FSM states:** IDLE, LC_PULSE, LC_WAIT_BUSY, LC_WAIT_DONE, DR_ASSERT, DR_WAIT_DONE.
- **IDLE:**
  - If FIFO is non-empty: pop the head.
  - Coefficient: register data into `fir_coefficient`, go to LC_PULSE.
  - Sample: register data into `sample_data`, go to DR_ASSERT.
- **LC_PULSE:** `load_coeff`=1 for exactly `LC_PULSE` cycles, then go to LC_WAIT_BUSY.
- **LC_WAIT_BUSY:**
  - `modwait`=1 → LC_WAIT_DONE.
  - If `modwait` was already high during the pulse, go straight to LC_WAIT_DONE.
- **LC_WAIT_DONE:** `modwait`=0 → IDLE.
- **DR_ASSERT:** `data_ready`=1 until `modwait`=1 is sampled; `data_ready` drops the next cycle → DR_WAIT_DONE.
- **DR_WAIT_DONE:** `modwait`=0 → IDLE.
- **Timeout:**
  - Counter clears on every state entry and counts in LC_WAIT_BUSY, LC_WAIT_DONE, DR_ASSERT and DR_WAIT_DONE.
  - Reaching `TIMEOUT` sets `timeout_err`, deasserts the handshake, discards the entry and returns to IDLE.
- **Errors:**
  - `clr_err` clears both sticky flags.
  - If `clr_err` and a set event land in the same cycle, the set wins.
- **Reset mid-transfer:** FIFO flushed, FSM to IDLE, handshake dropped immediately. The filter must be reset alongside.

## Timing
- Reset values:
  - `data_ready`, `load_coeff`, `busy`, `wr_full`, `overflow_err`, `timeout_err` = 0.
  - `fifo_empty` = 1.
  - `sample_data`, `fir_coefficient` = 0.
- All outputs are registered except `wr_full` and `fifo_empty`.
- **Latency:**
  - A word written at cycle n appears at IDLE head at n+1.
  - The handshake output rises at n+2 if the FSM is idle.
- `sample_data` / `fir_coefficient` hold their value from handshake assertion until the next pop.
- Minimum spacing between transfers is one IDLE cycle.

## Structure
- **`fir_feeder_pkg`:** state enum `feeder_state_t`, entry struct `feeder_entry_t`, width constant `DATA_W=16`. Shared with the AHB wrapper planned later.
- **Sub-module `sync_fifo`:** parameterized width and depth; push/pop/full/empty/count.
- **FSM and timeout counter:** live in `fir_feeder`.

## Test plan
- **Reset mid-transfer:**
  - Stimulus: `reset` during DR_WAIT_DONE.
  - Response: outputs return to their reset values next cycle and `fifo_empty`=1.
- **Coefficient load against `fir_filter` (0.5, 1.0, 1.0, 0.5 = 0x4000, 0x8000, 0x8000, 0x4000):**
  - Stimulus: four coefficient writes, then samples 100, 100, 100, 100.
  - Response: four `load_coeff` pulses of 2 cycles each, in order; `fir_out` sequence 0, 50, 50, 50; `err`=0.
- **Back-pressure:**
  - Stimulus: with `modwait` held high, write 9 samples.
  - Response: `wr_full`=1 after the 8th write, 9th write dropped, `overflow_err`=1.
- **Timeout:**
  - Stimulus: tie `modwait`=0 and send one sample.
  - Response: `data_ready` high for 25 cycles, then 0; `timeout_err`=1; FSM back in IDLE.
- **Error clear:**
  - Stimulus: pulse `clr_err` after a timeout.
  - Response: `timeout_err`=0; the next sample transfers normally.
